pwm_ramp_sched: RTL and testbench

PWM_RAMP_SCHED -- requirements
Module: pwm_ramp_sched

---
 rtl/pwm_ramp_sched_pkg.sv | 34 +++
 rtl/pwm_tick_div.sv | 30 +++
 rtl/pwm_ramp_sched.sv | 151 +++++++++++++++
 tb/tb_pwm_ramp_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_sched_pkg.sv
// Shared types and constants for the PWM ramp scheduler: FSM encoding,
// load-strobe timing and the saturating ramp-step helper.
package pwm_ramp_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_NEXT
    } state_e;

    localparam int LOAD_HI_CYC = 2;
    localparam int LOAD_LO_CYC = 2;
    localparam int HOLD_W = $clog2((LOAD_HI_CYC > LOAD_LO_CYC) ? LOAD_HI_CYC : LOAD_LO_CYC);

    // One ramp step toward tgt; 9-bit intermediates clamp at tgt so the result never overshoots or wraps.
    function automatic logic [7:0] ramp_next(input logic [7:0] lvl, input logic [7:0] tgt,
                                             input logic [7:0] step);
        logic [8:0] up;
        logic [8:0] dn;
        logic [7:0] res;
        up  = {1'b0, lvl} + {1'b0, step};
        dn  = {1'b0, lvl} - {1'b0, step};
        res = lvl;
        if (lvl < tgt) begin
            res = (up >= {1'b0, tgt}) ? tgt : up[7:0];
        end else if (lvl > tgt) begin
            res = (dn[8] || (dn[7:0] <= tgt)) ? tgt : dn[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// Ramp-tick prescaler: counts 0..RAMP_DIV-1 and pulses tick_o for one cycle on the last count.
module pwm_tick_div #(
    parameter int RAMP_DIV = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = $clog2(RAMP_DIV);
    localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_sched.sv
// Ramps per-channel duty levels toward written targets, one step per tick, and
// loads each changed level into its pwm instance over a shared data bus.
module pwm_ramp_sched
    import pwm_ramp_sched_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int RAMP_DIV  = 1000,
    parameter int RAMP_STEP = 1
) (
    input  logic                        masterClk,
    input  logic                        reset,
    input  logic [7:0]                  targetData,
    input  logic [$clog2(CHANNELS)-1:0] targetCh,
    input  logic                        targetWr,
    output logic [7:0]                  pwmData,
    output logic [CHANNELS-1:0]         pwmLoad,
    output logic                        busy,
    output logic                        overrun
);

    localparam int CH_W = $clog2(CHANNELS);
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(CHANNELS - 1);
    localparam logic [CH_W:0]     CH_LIM  = (CH_W + 1)'(CHANNELS);
    localparam logic [7:0]        STEP    = 8'(RAMP_STEP);
    localparam logic [HOLD_W-1:0] HI_LAST = HOLD_W'(LOAD_HI_CYC - 1);
    localparam logic [HOLD_W-1:0] LO_LAST = HOLD_W'(LOAD_LO_CYC - 1);

    state_e                     state_q, state_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [HOLD_W-1:0]          hold_q, hold_d;
    logic                       pending_q, pending_d;
    logic                       overrun_q, overrun_d;
    logic [7:0]                 data_q, data_d;
    logic [CHANNELS-1:0][7:0]   level_q;
    logic [CHANNELS-1:0][7:0]   target_q;

    logic       tick;
    logic       lvl_we;
    logic       wr_ok;
    logic [7:0] cur_lvl;
    logic [7:0] cur_tgt;
    logic [7:0] next_lvl;

    pwm_tick_div #(
        .RAMP_DIV (RAMP_DIV)
    ) u_tick_div (
        .clk_i  (masterClk),
        .rst_i  (reset),
        .tick_o (tick)
    );

    assign cur_lvl  = level_q[ch_q];
    assign cur_tgt  = target_q[ch_q];
    assign next_lvl = ramp_next(cur_lvl, cur_tgt, STEP);
    assign wr_ok    = targetWr && ({1'b0, targetCh} < CH_LIM);

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        data_d    = data_q;
        lvl_we    = 1'b0;

        // A busy FSM can bank one tick; a second one is lost and flagged.
        if (tick && (state_q != ST_IDLE)) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick || pending_q) begin
                    if (tick && pending_q) overrun_d = 1'b1;
                    pending_d = 1'b0;
                    ch_d      = '0;
                    state_d   = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (next_lvl != cur_lvl) begin
                    lvl_we  = 1'b1;
                    data_d  = next_lvl;
                    hold_d  = '0;
                    state_d = ST_LOAD_HI;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_LOAD_HI: begin
                if (hold_q == HI_LAST) begin
                    hold_d  = '0;
                    state_d = ST_LOAD_LO;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_LOAD_LO: begin
                if (hold_q == LO_LAST) begin
                    hold_d  = '0;
                    state_d = ST_NEXT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_NEXT: begin
                if (ch_q == CH_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = ST_EVAL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pwmLoad = '0;
        if (state_q == ST_LOAD_HI) pwmLoad[ch_q] = 1'b1;
    end

    // Drive the bus from data_d so a new value appears during EVAL, a full cycle ahead of the load rise.
    assign pwmData = data_d;
    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

    always_ff @(posedge masterClk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            data_q    <= '0;
            level_q   <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            data_q    <= data_d;
            if (lvl_we) level_q[ch_q] <= next_lvl;
            if (wr_ok)  target_q[targetCh] <= targetData;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_sched.sv
// Scoreboard bench: two schedulers (step 1 and step 100) share stimulus; a negedge
// monitor pops the expected {channel, data} for every pwmLoad pulse it sees.
module tb_pwm_ramp_sched;

    localparam int CH = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [7:0]    tdata = '0;
    logic [1:0]    tch   = '0;
    logic          twr   = 1'b0;
    logic [7:0]    data_a, data_b;
    logic [CH-1:0] load_a, load_b;
    logic          busy_a, busy_b, ovr_a, ovr_b;

    int tests = 0;
    int fails = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    always #5 clk = ~clk;

    pwm_ramp_sched #(.CHANNELS(CH), .RAMP_DIV(16), .RAMP_STEP(1)) u_dut_a (
        .masterClk (clk), .reset (rst), .targetData (tdata), .targetCh (tch), .targetWr (twr),
        .pwmData (data_a), .pwmLoad (load_a), .busy (busy_a), .overrun (ovr_a)
    );

    pwm_ramp_sched #(.CHANNELS(CH), .RAMP_DIV(16), .RAMP_STEP(100)) u_dut_b (
        .masterClk (clk), .reset (rst), .targetData (tdata), .targetCh (tch), .targetWr (twr),
        .pwmData (data_b), .pwmLoad (load_b), .busy (busy_b), .overrun (ovr_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ent(input int ch, input int v);
        return {2'(ch), 8'(v)};
    endfunction

    function automatic int oh2i(input logic [CH-1:0] v);
        for (int i = 0; i < CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    logic [CH-1:0] prev_load[2];
    logic [7:0]    prev_data[2];
    int            width[2];

    always @(negedge clk) begin : mon
        logic [CH-1:0] ml;
        logic [7:0]    md;
        logic          mb;
        logic [9:0]    ex;
        int            qs;
        for (int d = 0; d < 2; d++) begin
            ml = (d == 0) ? load_a : load_b;
            md = (d == 0) ? data_a : data_b;
            mb = (d == 0) ? busy_a : busy_b;
            if (rst) begin
                prev_load[d] = '0;
                width[d]     = 0;
            end else begin
                if (ml != '0) begin
                    chk($sformatf("dut%0d load onehot", d), int'($onehot(ml)), 1);
                    chk($sformatf("dut%0d busy during load", d), int'(mb), 1);
                    if (prev_load[d] == '0) begin
                        width[d] = 1;
                        chk($sformatf("dut%0d data setup", d), int'(md), int'(prev_data[d]));
                        qs = (d == 0) ? qa.size() : qb.size();
                        if (qs == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL dut%0d unexpected pulse: ch %0d data %0d, want none",
                                     d, oh2i(ml), md);
                        end else begin
                            if (d == 0) ex = qa.pop_front();
                            else        ex = qb.pop_front();
                            chk($sformatf("dut%0d pulse ch", d), oh2i(ml), int'(ex[9:8]));
                            chk($sformatf("dut%0d pulse data", d), int'(md), int'(ex[7:0]));
                        end
                    end else begin
                        width[d]++;
                    end
                end else if (prev_load[d] != '0) begin
                    chk($sformatf("dut%0d pulse width", d), width[d], 2);
                end
                prev_load[d] = ml;
            end
            prev_data[d] = md;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int val);
        tch   = 2'(ch);
        tdata = 8'(val);
        twr   = 1'b1;
        cyc(1);
        twr   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        twr = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("rst load_a", int'(load_a), 0);
        chk("rst data_a", int'(data_a), 0);
        chk("rst busy_a", int'(busy_a), 0);
        chk("rst ovr_a",  int'(ovr_a), 0);
        chk("rst load_b", int'(load_b), 0);
        chk("rst data_b", int'(data_b), 0);
        chk("rst busy_b", int'(busy_b), 0);
        chk("rst ovr_b",  int'(ovr_b), 0);
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string name, input int maxc);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < maxc) begin
            cyc(1);
            n++;
        end
        chk({name, " pending A"}, qa.size(), 0);
        chk({name, " pending B"}, qb.size(), 0);
        cyc(80);
    endtask

    initial begin
        int n;
        int run_a;
        int run_b;

        // Step-1 ramp to 3 versus a single clamped step-100 load.
        do_reset();
        for (int k = 1; k <= 3; k++) qa.push_back(ent(0, k));
        qb.push_back(ent(0, 3));
        wr(0, 3);
        drain("ramp to 3", 400);

        // Saturating up/down ramps, no overshoot or wrap.
        do_reset();
        for (int k = 1; k <= 250; k++) qa.push_back(ent(0, k));
        qb.push_back(ent(0, 100));
        qb.push_back(ent(0, 200));
        qb.push_back(ent(0, 250));
        wr(0, 250);
        drain("ramp up 250", 4500);
        for (int k = 249; k >= 10; k--) qa.push_back(ent(0, k));
        qb.push_back(ent(0, 150));
        qb.push_back(ent(0, 50));
        qb.push_back(ent(0, 10));
        wr(0, 10);
        drain("ramp down 10", 4500);

        // Targets 5,0,7,0: ch0 then ch2, busy for the whole 16-cycle sweep.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            qa.push_back(ent(0, k));
            qa.push_back(ent(2, k));
        end
        qa.push_back(ent(2, 6));
        qa.push_back(ent(2, 7));
        qb.push_back(ent(0, 5));
        qb.push_back(ent(2, 7));
        wr(0, 5);
        wr(1, 0);
        wr(2, 7);
        wr(3, 0);
        n = 0;
        while (!busy_b && n < 100) begin
            cyc(1);
            n++;
        end
        chk("sweep start", int'(busy_b), 1);
        run_a = 0;
        run_b = 0;
        n = 0;
        while ((busy_a || busy_b) && n < 100) begin
            run_a += int'(busy_a);
            run_b += int'(busy_b);
            cyc(1);
            n++;
        end
        chk("busy run a", run_a, 16);
        chk("busy run b", run_b, 16);
        drain("sweep 5070", 1500);

        // All four channels changing at step 1: second banked tick raises overrun.
        do_reset();
        for (int k = 1; k <= 3; k++)
            for (int c = 0; c < CH; c++) qa.push_back(ent(c, k));
        for (int c = 0; c < CH; c++) qb.push_back(ent(c, 3));
        for (int c = 0; c < CH; c++) wr(c, 3);
        cyc(41);
        chk("ovr_a early", int'(ovr_a), 0);
        chk("ovr_b early", int'(ovr_b), 0);
        cyc(55);
        chk("ovr_a set", int'(ovr_a), 1);
        chk("ovr_b clear", int'(ovr_b), 0);
        drain("overrun sweep", 1000);
        cyc(200);
        chk("ovr_a sticky", int'(ovr_a), 1);
        do_reset();

        // Reset in the second LOAD_HI cycle.
        qa.push_back(ent(0, 1));
        qb.push_back(ent(0, 3));
        wr(0, 3);
        n = 0;
        while (load_a == '0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("reach load_hi", int'(load_a != '0), 1);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("mid rst load_a", int'(load_a), 0);
        chk("mid rst data_a", int'(data_a), 0);
        chk("mid rst busy_a", int'(busy_a), 0);
        chk("mid rst load_b", int'(load_b), 0);
        chk("mid rst data_b", int'(data_b), 0);
        chk("mid rst busy_b", int'(busy_b), 0);
        qa.delete();
        qb.delete();
        cyc(1);
        rst = 1'b0;
        qa.push_back(ent(0, 1));
        qa.push_back(ent(0, 2));
        qb.push_back(ent(0, 2));
        wr(0, 2);
        drain("after mid rst", 600);

        // Write ch1 during its EVAL: old target 30 now, new target 130 next sweep.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            qa.push_back(ent(0, k));
            qa.push_back(ent(1, k));
        end
        for (int k = 11; k <= 130; k++) qa.push_back(ent(1, k));
        qb.push_back(ent(0, 10));
        qb.push_back(ent(1, 30));
        qb.push_back(ent(1, 130));
        wr(0, 10);
        wr(1, 30);
        n = 0;
        while (load_b == '0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("reach ch0 load", int'(load_b != '0), 1);
        cyc(5);
        wr(1, 130);
        drain("eval collision", 4500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
